pwm_pulse_decoder: RTL

Measures the high time and repetition period of an incoming hobby-servo PWM signal in whole microseconds and reports each completed pulse with range and timeout status. It is the receive-side counterpart of the servo PWM generator: it lets the design read commands from an external RC receiver, or loop a generated `pwm_out` bit back for self-check. One instance decodes one channel, and multi-channel use instantiates it per bit.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/us_tick_gen.sv | 18 +
 rtl/pwm_pulse_decoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared by the servo PWM generator and decoder.
package pwm_pkg;
   typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH} pwm_dec_state_t;
   localparam int PWM_MIN_US    = 1000;
   localparam int PWM_MAX_US    = 2000;
   localparam int PWM_PERIOD_US = 20000;
   function automatic int cycles_per_us(input int clk_hz);
      return clk_hz / 1_000_000;
   endfunction
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: microsecond prescaler with synchronous restart; us_tick marks the wrap cycle.
module us_tick_gen
   import pwm_pkg::*;
#(
   parameter int DIV = cycles_per_us(50_000_000)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic us_tick
);
   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] cnt;
   assign us_tick = cnt == LAST;
   always_ff @(posedge clk)
      cnt <= (!reset_n || restart || us_tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/pwm_pulse_decoder.sv
// pwm_pulse_decoder: measures servo PWM high time and rise-to-rise period in whole
// microseconds, flagging out-of-range widths and a silent line.
module pwm_pulse_decoder
   import pwm_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int MIN_US      = PWM_MIN_US,
   parameter int MAX_US      = PWM_MAX_US,
   parameter int TIMEOUT_US  = 25000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pwm_in,
   output logic [15:0] width_us,
   output logic [15:0] period_us,
   output logic        sample_stb,
   output logic        valid,
   output logic        out_of_range,
   output logic        timeout
);
   localparam int DIV = cycles_per_us(CLK_HZ);
   localparam logic [15:0] LO      = 16'(MIN_US);
   localparam logic [15:0] HI      = 16'(MAX_US);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_US - 1);

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic t);
      return (t && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   pwm_dec_state_t state;
   logic [SYNC_STAGES-1:0] sync;
   logic s_q, rise, fall, us_tick, prev_rise, idle_hit, oor_now;
   logic [15:0] hi_us, per_us, idle_us, hi_now, per_now;

   us_tick_gen #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (rise | fall),
      .us_tick (us_tick)
   );

   // A tick landing on the closing edge still belongs to the interval being closed.
   assign hi_now   = sat_inc(hi_us, us_tick);
   assign per_now  = sat_inc(per_us, us_tick);
   assign oor_now  = (hi_now < LO) || (hi_now > HI);
   assign idle_hit = us_tick && idle_us == TO_LAST && !(rise || fall);

   // Left unreset so a line already high at reset release is seen as high, not as a rise.
   always_ff @(posedge clk) begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_q  <= sync[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rise         <= 1'b0;
         fall         <= 1'b0;
         state        <= ARM;
         prev_rise    <= 1'b0;
         hi_us        <= '0;
         per_us       <= '0;
         idle_us      <= '0;
         width_us     <= '0;
         period_us    <= '0;
         sample_stb   <= 1'b0;
         valid        <= 1'b0;
         out_of_range <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         rise       <= sync[SYNC_STAGES-1] & ~s_q;
         fall       <= ~sync[SYNC_STAGES-1] & s_q;
         sample_stb <= 1'b0;
         hi_us      <= rise ? '0 : (state == HIGH ? hi_now : hi_us);
         per_us     <= rise ? '0 : per_now;
         idle_us    <= (rise || fall) ? '0 : sat_inc(idle_us, us_tick);
         case (state)
            ARM: if (!s_q) state <= WAIT_RISE;
            WAIT_RISE: begin
               if (rise) begin
                  state     <= HIGH;
                  prev_rise <= 1'b1;
                  if (prev_rise) period_us <= per_now;
               end else if (idle_hit) begin
                  timeout   <= 1'b1;
                  valid     <= 1'b0;
                  prev_rise <= 1'b0;
               end
            end
            HIGH: begin
               if (fall) begin
                  state        <= WAIT_RISE;
                  width_us     <= hi_now;
                  sample_stb   <= 1'b1;
                  out_of_range <= oor_now;
                  valid        <= !oor_now;
                  timeout      <= 1'b0;
               end else if (idle_hit) begin
                  state   <= ARM;
                  timeout <= 1'b1;
                  valid   <= 1'b0;
               end
            end
            default: state <= ARM;
         endcase
      end
   end
endmodule
